// File: rtl/ad4003_sdo_capture_if.sv
// Handshake/data bundle between the AD4003 SDO capture block and its driver/consumer.
// The capture block takes the slave view; the master view drives the window, lanes and ready.
interface ad4003_sdo_capture_if #(
    parameter int N_CH = 2
) ();
    logic                 reader_en_sync;
    logic [N_CH-1:0]      adc_sdo;
    logic                 data_ready;
    logic [N_CH*32-1:0]   adc_data;
    logic                 data_valid;
    logic                 frame_err;
    logic                 overrun;
    logic [15:0]          sample_cnt;

    modport master (
        output reader_en_sync, adc_sdo, data_ready,
        input  adc_data, data_valid, frame_err, overrun, sample_cnt
    );

    modport slave (
        input  reader_en_sync, adc_sdo, data_ready,
        output adc_data, data_valid, frame_err, overrun, sample_cnt
    );
endinterface

// File: rtl/ad4003_sdo_capture.sv
// Multi-lane AD4003 SDO deserializer: 18-bit frame check, valid/ready output and overrun flag.
// Define AD4003_SIGN_EXT_EN to sign-extend each sample to 32 bits; otherwise upper bits are 0.
module ad4003_sdo_capture #(
    parameter int TCQ  = 1,
    parameter int N_CH = 2
) (
    input logic                 adc_read_clk,
    input logic                 rst,
    ad4003_sdo_capture_if.slave bus
);
    localparam int unsigned FrameBits = 18;

    typedef enum logic [1:0] {StArm, StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [17:0]        shift_q [N_CH];
    logic [17:0]        shift_d [N_CH];
    logic [N_CH*32-1:0] adc_data_q, adc_data_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        sample_cnt_q, sample_cnt_d;
    logic               frame_end, frame_good;

    if (N_CH < 1 || N_CH > 16 || TCQ < 0) begin : g_param_check
        $error("ad4003_sdo_capture: N_CH must be 1..16 and TCQ non-negative");
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        adc_data_d   = adc_data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        sample_cnt_d = sample_cnt_q;
        frame_end    = 1'b0;

        unique case (state_q)
            StArm: begin
                // Only arm once the window is seen closed, so a window in flight is skipped.
                if (!bus.reader_en_sync) state_d = StIdle;
            end
            StIdle: begin
                if (bus.reader_en_sync) begin
                    state_d   = StShift;
                    bit_cnt_d = 5'd1;
                    for (int k = 0; k < N_CH; k++) shift_d[k] = {17'b0, bus.adc_sdo[k]};
                end
            end
            StShift: begin
                if (bus.reader_en_sync) begin
                    for (int k = 0; k < N_CH; k++) begin
                        shift_d[k] = {shift_q[k][16:0], bus.adc_sdo[k]};
                    end
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end else begin
                    state_d   = StIdle;
                    frame_end = 1'b1;
                end
            end
            default: state_d = StArm;
        endcase

        frame_good  = frame_end && (bit_cnt_q == 5'(FrameBits));
        frame_err_d = frame_end && !frame_good;

        if (data_valid_q && bus.data_ready) data_valid_d = 1'b0;

        // A new frame wins over a same-cycle accept; overrun only if the old frame was not taken.
        if (frame_good) begin
            for (int k = 0; k < N_CH; k++) begin
`ifdef AD4003_SIGN_EXT_EN
                adc_data_d[32*k +: 32] = {{14{shift_q[k][17]}}, shift_q[k]};
`else
                adc_data_d[32*k +: 32] = {14'b0, shift_q[k]};
`endif
            end
            data_valid_d = 1'b1;
            sample_cnt_d = sample_cnt_q + 16'd1;
            if (data_valid_q && !bus.data_ready) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge adc_read_clk) begin
        if (rst) begin
            state_q      <= StArm;
            bit_cnt_q    <= '0;
            for (int k = 0; k < N_CH; k++) shift_q[k] <= '0;
            adc_data_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            for (int k = 0; k < N_CH; k++) shift_q[k] <= shift_d[k];
            adc_data_q   <= adc_data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign bus.adc_data   = adc_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.sample_cnt = sample_cnt_q;
endmodule

// File: doc/ad4003_sdo_capture.md
AD4003_SDO_CAPTURE -- requirements
Module: ad4003_sdo_capture

Interface
REQ-001 Parameter TCQ, default 1: register clock-to-q delay in ns, simulation only.
REQ-002 Parameter N_CH, default 2, range 1-16: number of ADC SDO lanes captured in parallel.
REQ-003 Port adc_read_clk, input, 1 bit: only clock, 80 MHz, phase-delayed read clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port reader_en_sync, input, 1 bit: capture window from the SPI master, already synchronized to adc_read_clk.
REQ-006 Port adc_sdo, input, N_CH bits: ADC serial data lanes, MSB first; bit k is channel k.
REQ-007 Port data_ready, input, 1 bit: consumer accepts the current frame.
REQ-008 Port adc_data, output, N_CH*32 bits: captured samples; channel k occupies bits [32k+31:32k].
REQ-009 Port data_valid, output, 1 bit: adc_data holds an unaccepted frame.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse when a window closes with a bit count other than 18.
REQ-011 Port overrun, output, 1 bit: sticky flag, set when a frame is lost.
REQ-012 Port sample_cnt, output, 16 bits: count of good frames, wraps at 0xFFFF to 0.

Function
REQ-013 FSM states:
- ARM: wait for reader_en_sync=0, then go to IDLE.
- IDLE: on reader_en_sync=1, go to SHIFT.
- SHIFT: on reader_en_sync=0, go to IDLE.
- No other transitions.
REQ-014 IDLE->SHIFT edge: bit_cnt loads 1; each lane's 18-bit shift register loads {17'b0, adc_sdo[k]}.
REQ-015 Every SHIFT cycle with reader_en_sync=1:
- each lane shifts left, inserting adc_sdo[k] at the LSB;
- bit_cnt increments, saturating at 31;
- result: the register keeps the last 18 bits sampled.
REQ-016 SHIFT->IDLE edge with bit_cnt==18:
- adc_data is loaded;
- data_valid=1 is set;
- sample_cnt increments.
- Latency: outputs are visible one cycle after the first low sample of reader_en_sync.
REQ-017 SHIFT->IDLE edge with bit_cnt!=18:
- frame_err pulses high for exactly one cycle;
- adc_data, data_valid and sample_cnt are unchanged.
REQ-018 data_valid clears on the cycle after data_valid && data_ready is sampled.
REQ-019 A good frame completing while data_valid=1 and data_ready=0:
- overwrites adc_data;
- keeps data_valid=1;
- sets overrun.
REQ-020 Simultaneous good-frame completion and data_valid && data_ready on the same edge:
- the new frame loads;
- data_valid stays 1;
- overrun is not set.
REQ-021 Each channel field = 18-bit two's-complement sample in bits [17:0]; the upper 14 bits follow REQ-029/REQ-030.
REQ-022 overrun clears only on rst.

Reset
REQ-023 Synchronous reset on rst=1; it overrides all other inputs.
REQ-024 Reset values: adc_data=0, data_valid=0, frame_err=0, overrun=0, sample_cnt=0, bit_cnt=0, shift registers=0, FSM=ARM.
REQ-025 rst asserted mid-frame discards the partial frame.
REQ-026 After rst release, capture starts only after reader_en_sync has been seen low (ARM), so a window already in progress is never captured.

Configuration
REQ-027 Macro AD4003_SIGN_EXT_EN selects the upper-bit handling of each channel field.
REQ-028 The macro changes no port, state or timing.
REQ-029 Defined: bits [32k+31:32k+18] replicate sample bit 17 (sign extension to 32 bits).
REQ-030 Undefined: bits [32k+31:32k+18] = 0.

Verification
REQ-031 Reset then 18-cycle window, lane0 pattern 0x2AAAA, lane1 pattern 0x00001:
- adc_data[17:0]=0x2AAAA, adc_data[49:32]=0x00001;
- data_valid=1 one cycle after window close;
- sample_cnt=1.
REQ-032 Lane0 0x20000 with AD4003_SIGN_EXT_EN defined -> adc_data[31:0]=0xFFFE0000.
- Same stimulus without the macro -> 0x00020000.
REQ-033 Window lengths 17 and 20 cycles:
- frame_err pulses once per window;
- data_valid and sample_cnt unchanged.
REQ-034 Two good frames (0x00011, then 0x00022) with data_ready=0 -> adc_data[17:0]=0x00022, data_valid=1, overrun=1.
- Then data_ready=1 for one cycle -> data_valid=0.
REQ-035 Boundary cases:
- rst pulsed at bit 9 of a window -> no output change after release;
- reset while reader_en_sync high -> the remainder of that window is ignored;
- next full window captures normally.
REQ-036 Preload sample_cnt to 0xFFFF via 65535 good frames, then one more good frame -> sample_cnt=0x0000, no other flag set.
